// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ debug dump engines.
// Each granted word is sent most-significant byte first over the tx_start/tx_done byte handshake.
module uart_tx_arbiter #(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int N_REQ   = 3
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_WORD-1:0] i_word,
  input  logic [N_REQ*2-1:0]       i_len,
  output logic [N_REQ-1:0]         o_ack,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_busy,
  output logic [NB_DATA-1:0]       o_tx_data,
  output logic                     o_tx_start,
  input  logic                     i_tx_done
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, ACK} state_t;

  localparam logic [1:0]       LAST_RESET = 2'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE        = N_REQ'(1);

  state_t             state;
  logic [NB_WORD-1:0] word_q;
  logic [1:0]         len_code_q;
  logic [1:0]         byte_cnt;
  logic [1:0]         last_grant;

  logic [NB_WORD-1:0] req_words [N_REQ];
  logic [1:0]         req_lens  [N_REQ];
  logic               arb_found;
  logic [1:0]         arb_idx;
  logic [2:0]         cand;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_words[k] = i_word[k*NB_WORD +: NB_WORD];
    assign req_lens[k]  = i_len[k*2 +: 2];
  end

  // Byte position 0 is bits [NB_DATA-1:0]; the caller supplies the position to send.
  function automatic logic [NB_DATA-1:0] byte_at(input logic [NB_WORD-1:0] w,
                                                 input logic [1:0] pos);
    logic [NB_DATA-1:0] r;
    r = '0;
    for (int i = 0; i < NB_WORD / NB_DATA; i++)
      if (pos == 2'(i)) r = w[i*NB_DATA +: NB_DATA];
    return r;
  endfunction

  // Search from last_grant+1 upward with wrap; the first set request wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant} + 3'(k);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      if (!arb_found && i_req[cand[1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[1:0];
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      word_q     <= '0;
      len_code_q <= '0;
      byte_cnt   <= '0;
      last_grant <= LAST_RESET;
      o_ack      <= '0;
      o_grant    <= '0;
      o_busy     <= 1'b0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            word_q     <= req_words[arb_idx];
            len_code_q <= req_lens[arb_idx];
            byte_cnt   <= '0;
            last_grant <= arb_idx;
            o_grant    <= ONE << arb_idx;
            o_busy     <= 1'b1;
            o_tx_start <= 1'b1;
            o_tx_data  <= byte_at(req_words[arb_idx], req_lens[arb_idx]);
            state      <= SEND;
          end
        end
        SEND: begin
          o_tx_start <= 1'b0;
          state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (i_tx_done) begin
            if (byte_cnt == len_code_q) begin
              o_ack <= o_grant;
              state <= ACK;
            end else begin
              // Next position is len-1-(byte_cnt+1), i.e. code-byte_cnt-1.
              byte_cnt   <= byte_cnt + 2'd1;
              o_tx_start <= 1'b1;
              o_tx_data  <= byte_at(word_q, len_code_q - byte_cnt - 2'd1);
              state      <= SEND;
            end
          end
        end
        ACK: begin
          o_ack   <= '0;
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a fixed vector table, hand-written reset/spurious
// sequences and randomized transfers checked against a round-robin/byte-order reference model.
module tb_uart_tx_arbiter;
  localparam int NB_DATA = 8;
  localparam int NB_WORD = 32;
  localparam int N_REQ   = 3;

  logic                     i_clock = 1'b0;
  logic                     i_reset;
  logic [N_REQ-1:0]         i_req;
  logic [N_REQ*NB_WORD-1:0] i_word;
  logic [N_REQ*2-1:0]       i_len;
  logic [N_REQ-1:0]         o_ack;
  logic [N_REQ-1:0]         o_grant;
  logic                     o_busy;
  logic [NB_DATA-1:0]       o_tx_data;
  logic                     o_tx_start;
  logic                     i_tx_done;

  always #5 i_clock = ~i_clock;

  uart_tx_arbiter #(.NB_DATA(NB_DATA), .NB_WORD(NB_WORD), .N_REQ(N_REQ)) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_req     (i_req),
    .i_word    (i_word),
    .i_len     (i_len),
    .o_ack     (o_ack),
    .o_grant   (o_grant),
    .o_busy    (o_busy),
    .o_tx_data (o_tx_data),
    .o_tx_start(o_tx_start),
    .i_tx_done (i_tx_done)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int modelLast   = N_REQ - 1;

  logic [7:0] gotBytes[$];
  int gotGrant, gotAck, firstStart, ackCycle, lastDoneCycle, lateStarts;
  bit timedOut, gapOk, ackGrantMatch;

  typedef struct {
    logic [2:0]  req;
    int          slot;
    logic [31:0] word;
    logic [1:0]  code;
    int          expGrant;
    logic [31:0] expPacked;
    int          expCount;
  } vec_t;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int onehotIdx(input logic [2:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration: first requester after the previous winner, cyclically.
  function automatic int modelPick(input logic [2:0] mask);
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (modelLast + k) % N_REQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic setSlot(input int k, input logic [31:0] w, input logic [1:0] code);
    i_word[k*NB_WORD +: NB_WORD] = w;
    i_len[k*2 +: 2]              = code;
  endtask

  // Plays the UART side for one word: answers every start with a done pulse doneDelay cycles later.
  task automatic applyStimulus(input int doneDelay, input bit dropOnAck, input bit spurious,
                               input bit scramble);
    int  cnt;
    bit  waiting;
    gotBytes.delete();
    gotGrant = -1; gotAck = -1; firstStart = -1; ackCycle = -1; lastDoneCycle = -1;
    lateStarts = 0; timedOut = 1'b1; gapOk = 1'b0; ackGrantMatch = 1'b0;
    waiting = 1'b0; cnt = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge i_clock);
      i_tx_done = 1'b0;
      if (o_ack != '0) begin
        gotAck        = onehotIdx(o_ack);
        ackCycle      = cyc;
        ackGrantMatch = (o_grant === o_ack);
        if (dropOnAck) i_req = i_req & ~o_ack;
        @(negedge i_clock);
        gapOk    = (o_busy == 1'b0 && o_grant == '0 && o_tx_start == 1'b0 && o_ack == '0);
        timedOut = 1'b0;
        break;
      end
      if (o_tx_start) begin
        if (gotBytes.size() > 0 && cyc != lastDoneCycle + 1) lateStarts++;
        gotBytes.push_back(o_tx_data);
        if (firstStart < 0) begin
          firstStart = cyc;
          gotGrant   = onehotIdx(o_grant);
        end
        waiting = 1'b1;
        cnt     = doneDelay;
        if (spurious) i_tx_done = 1'b1;
        if (scramble && gotBytes.size() == 1) begin
          i_word = {$urandom, $urandom, $urandom};
          i_len  = 6'($urandom);
        end
      end else if (waiting) begin
        cnt--;
        if (cnt == 0) begin
          i_tx_done     = 1'b1;
          waiting       = 1'b0;
          lastDoneCycle = cyc;
        end
      end
    end
    i_tx_done = 1'b0;
  endtask

  task automatic checkTransfer(input string tag, input int expGrant, input logic [31:0] expPacked,
                               input int expCount);
    checkOutput({tag, " timeout"}, int'(timedOut), 0);
    checkOutput({tag, " start latency"}, firstStart, 1);
    checkOutput({tag, " grant"}, gotGrant, expGrant);
    checkOutput({tag, " ack"}, gotAck, expGrant);
    checkOutput({tag, " ack equals grant"}, int'(ackGrantMatch), 1);
    checkOutput({tag, " ack timing"}, ackCycle, lastDoneCycle + 1);
    checkOutput({tag, " inter-byte latency"}, lateStarts, 0);
    checkOutput({tag, " byte count"}, gotBytes.size(), expCount);
    for (int i = 0; i < expCount; i++) begin
      int act;
      act = (i < gotBytes.size()) ? int'(gotBytes[i]) : -1;
      checkOutput($sformatf("%s byte%0d", tag, i), act,
                  int'((expPacked >> (8 * (expCount - 1 - i))) & 32'hFF));
    end
    checkOutput({tag, " idle gap after ack"}, int'(gapOk), 1);
    modelLast = expGrant;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " tx_start"}, int'(o_tx_start), 0);
    checkOutput({tag, " busy"}, int'(o_busy), 0);
    checkOutput({tag, " grant"}, int'(o_grant), 0);
    checkOutput({tag, " ack"}, int'(o_ack), 0);
    checkOutput({tag, " tx_data"}, int'(o_tx_data), 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{3'b001, 0, 32'h12345678, 2'd3, 0, 32'h12345678, 4};
    vecs[1] = '{3'b010, 1, 32'hAABBCCDD, 2'd0, 1, 32'h000000DD, 1};
    vecs[2] = '{3'b010, 1, 32'hAABBCCDD, 2'd1, 1, 32'h0000CCDD, 2};
    vecs[3] = '{3'b100, 2, 32'hCAFEF00D, 2'd2, 2, 32'h00FEF00D, 3};
    vecs[4] = '{3'b101, 0, 32'h0000A55A, 2'd1, 0, 32'h0000A55A, 2};
    vecs[5] = '{3'b110, 1, 32'h01020304, 2'd3, 1, 32'h01020304, 4};

    i_reset = 1'b1; i_req = '0; i_word = '0; i_len = '0; i_tx_done = 1'b0;
    repeat (2) @(negedge i_clock);
    checkAllZero("reset");
    i_reset = 1'b0;

    // Done pulse while idle with no request must not wake the arbiter.
    i_tx_done = 1'b1;
    @(negedge i_clock);
    i_tx_done = 1'b0;
    checkOutput("idle spurious done busy", int'(o_busy), 0);
    checkOutput("idle spurious done start", int'(o_tx_start), 0);

    for (int i = 0; i < 6; i++) begin
      i_word = {$urandom, $urandom, $urandom};
      i_len  = 6'($urandom);
      setSlot(vecs[i].slot, vecs[i].word, vecs[i].code);
      i_req = vecs[i].req;
      applyStimulus(1 + (i % 3), 1'b1, (i == 1 || i == 3), (i >= 3));
      checkTransfer($sformatf("vec%0d", i), vecs[i].expGrant, vecs[i].expPacked,
                    vecs[i].expCount);
    end

    // All requesters held: grants must rotate, one word each, with an idle cycle between.
    i_word = {$urandom, $urandom, $urandom};
    i_len  = 6'b01_01_01;
    i_req  = 3'b111;
    for (int n = 0; n < 6; n++) begin
      int g;
      g = modelPick(3'b111);
      applyStimulus(2, 1'b0, 1'b0, 1'b0);
      checkTransfer($sformatf("rr%0d", n), g, i_word[g*NB_WORD +: NB_WORD] & 32'hFFFF, 2);
    end
    i_req = '0;

    // Reset in the middle of a 4-byte word, after the second byte has been started.
    begin
      int  starts;
      bit  reached;
      setSlot(0, 32'h11223344, 2'd3);
      i_req   = 3'b001;
      starts  = 0;
      reached = 1'b0;
      for (int cyc = 0; cyc < 50 && !reached; cyc++) begin
        @(negedge i_clock);
        i_tx_done = 1'b0;
        if (o_tx_start) starts++;
        else if (o_busy && starts > 0) begin
          if (starts == 2) reached = 1'b1;
          else i_tx_done = 1'b1;
        end
      end
      checkOutput("reset setup reached byte2", int'(reached), 1);
      #2 i_reset = 1'b1;
      #1 checkAllZero("async reset");
      repeat (2) begin
        @(negedge i_clock);
        checkOutput("no ack during reset", int'(o_ack), 0);
      end
      i_reset   = 1'b0;
      modelLast = N_REQ - 1;
      applyStimulus(1, 1'b1, 1'b0, 1'b0);
      checkTransfer("after reset", modelPick(3'b001), 32'h11223344, 4);
    end

    // Randomized transfers against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  mask;
      logic [95:0] words;
      logic [5:0]  lens;
      int          g;
      int          code;
      mask  = 3'($urandom_range(1, 7));
      words = {$urandom, $urandom, $urandom};
      lens  = 6'($urandom);
      i_word = words;
      i_len  = lens;
      i_req  = mask;
      g    = modelPick(mask);
      code = int'(lens[g*2 +: 2]);
      applyStimulus(int'($urandom_range(1, 4)), 1'b1, 1'($urandom), 1'($urandom));
      checkTransfer($sformatf("rand%0d", n), g,
                    32'((64'(words[g*NB_WORD +: NB_WORD])) & ((64'd1 << (8 * (code + 1))) - 64'd1)),
                    code + 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
